// File: rtl/io_map_ctrl.sv
// io_map_ctrl: memory-mapped IO beside a dual-port memory (out regs, synced inputs, read-to-clear status); define IO_MAP_IRQ_EN for MASK and irq
module io_map_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IO_BASE_BIT = 9,
    parameter int NUM_IN = 4,
    parameter int NUM_OUT = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          addr_a,
    input  logic [ADDR_WIDTH-1:0]          addr_b,
    input  logic [DATA_WIDTH-1:0]          data_a,
    input  logic [DATA_WIDTH-1:0]          data_b,
    input  logic                           write_a,
    input  logic                           write_b,
    input  logic [DATA_WIDTH-1:0]          mem_read_a,
    input  logic [DATA_WIDTH-1:0]          mem_read_b,
    output logic                           mem_write_a,
    output logic                           mem_write_b,
    output logic [DATA_WIDTH-1:0]          ReadDataA,
    output logic [DATA_WIDTH-1:0]          ReadDataB,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_OUT*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_OUT-1:0]             out_strobe,
    output logic                           irq
);
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic                  wr [2];
    logic                  io [2];
    logic                  rd_status [2];
    logic [DATA_WIDTH-1:0] rd_next [2];
    logic [DATA_WIDTH-1:0] rd_word [2];
    logic                  sel_io [2];
    logic [NUM_OUT-1:0]    hit_out [2];
    logic [DATA_WIDTH-1:0] out_reg [NUM_OUT];
    logic [DATA_WIDTH-1:0] sync [SYNC_STAGES][NUM_IN];
    logic [DATA_WIDTH-1:0] prev [NUM_IN];
    logic [NUM_IN-1:0]     flags;
    logic [NUM_IN-1:0]     chg;
    logic                  unused_addr;
`ifdef IO_MAP_IRQ_EN
    logic [NUM_IN-1:0]     mask;
    logic                  hit_mask [2];
`endif

    assign addr[0] = addr_a;
    assign addr[1] = addr_b;
    assign wdata[0] = data_a;
    assign wdata[1] = data_b;
    assign wr[0] = write_a;
    assign wr[1] = write_b;
    assign unused_addr = ^{addr_a, addr_b};
    assign mem_write_a = write_a & ~io[0] & ~reset;
    assign mem_write_b = write_b & ~io[1] & ~reset;
    assign ReadDataA = sel_io[0] ? rd_word[0] : mem_read_a;
    assign ReadDataB = sel_io[1] ? rd_word[1] : mem_read_b;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = out_reg[i];
    end

    // Per-port address decode, IO read word selection and input change detection
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            io[p] = |addr[p][ADDR_WIDTH-1:IO_BASE_BIT];
            rd_status[p] = io[p] & ~wr[p] & (addr[p][7:0] == 8'h1F);
            rd_next[p] = '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                hit_out[p][i] = io[p] & wr[p] & (addr[p][7:0] == 8'(i));
                if (addr[p][7:0] == 8'(i)) rd_next[p] = out_reg[i];
            end
            for (int i = 0; i < NUM_IN; i++)
                if (addr[p][7:0] == 8'(16 + i)) rd_next[p] = sync[SYNC_STAGES-1][i];
            if (addr[p][7:0] == 8'h1F) rd_next[p] = DATA_WIDTH'(flags);
`ifdef IO_MAP_IRQ_EN
            hit_mask[p] = io[p] & wr[p] & (addr[p][7:0] == 8'h1E);
            if (addr[p][7:0] == 8'h1E) rd_next[p] = DATA_WIDTH'(mask);
`endif
        end
        for (int i = 0; i < NUM_IN; i++)
            chg[i] = sync[SYNC_STAGES-1][i] != prev[i];
    end

    // Register the IO read word and the mem/IO select to match the memory's read latency
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            sel_io[p] <= reset | (io[p] & ~wr[p]);
            rd_word[p] <= reset ? '0 : rd_next[p];
        end
    end

    // Output channel registers with one-cycle strobes; port A wins a same-channel collision
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT; i++) begin
            if (reset) out_reg[i] <= '0;
            else if (hit_out[0][i]) out_reg[i] <= wdata[0];
            else if (hit_out[1][i]) out_reg[i] <= wdata[1];
        end
        out_strobe <= reset ? '0 : hit_out[0] | hit_out[1];
    end

    // Input synchronisers, previous-value flops and sticky change flags (new change beats a clear)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            sync[0][i] <= reset ? '0 : in_data[i*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s < SYNC_STAGES; s++) sync[s][i] <= reset ? '0 : sync[s-1][i];
            prev[i] <= reset ? '0 : sync[SYNC_STAGES-1][i];
        end
        flags <= reset ? '0 : (((rd_status[0] | rd_status[1]) ? '0 : flags) | chg);
    end

`ifdef IO_MAP_IRQ_EN
    // Interrupt mask register and registered interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            irq <= 1'b0;
        end else begin
            if (hit_mask[0]) mask <= wdata[0][NUM_IN-1:0];
            else if (hit_mask[1]) mask <= wdata[1][NUM_IN-1:0];
            irq <= |(flags & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule
